la_dump_uart: RTL and testbench
===============================

Name: la_dump_uart

Overview:
Readout stage downstream of the logic-analyser capture RAM. After a capture completes, it walks the RAM read port from address 0 and streams the samples to the host over an 8N1 UART. Each dump is framed as a header byte, the payload bytes and a checksum byte. It runs in the clk_50M domain and drives the RAM read port with rd_clk = clk_50M.

Parameters:
CLK_HZ, 50000000, system clock frequency
BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer divide, 434 at defaults)
ADDR_W, 17, capture RAM address width
HDR_BYTE, 8'hA5, frame header value

Ports:
clk_50M  in  1  system clock, also the RAM read clock
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse that begins a dump; ignored while busy
abort  in  1  level; terminates the dump at the next byte boundary
dump_len  in  ADDR_W  last address to send; payload = dump_len+1 bytes; sampled on start
rd_addr  out  ADDR_W  capture RAM read address
rd_data  in  8  capture RAM read data, valid 1 cycle after rd_addr
uart_tx  out  1  serial output, idle high
busy  out  1  high from the cycle after start until done
done  out  1  1-cycle pulse at end of frame, normal or aborted

Behaviour:
- Reset: uart_tx=1, busy=0, done=0, rd_addr=0, checksum=0, FSM=IDLE. Applies even mid-frame; the line returns high the next cycle.
- FSM states: IDLE, HDR, FETCH, WAIT, SEND, CKSUM, FIN.
- IDLE --start--> HDR:
  - Latch dump_len into len_q.
  - Clear checksum and rd_addr.
  - Set busy the following cycle.
- HDR: load HDR_BYTE into the serializer, then go to FETCH. The header is excluded from the checksum.
- FETCH: present rd_addr, then go to WAIT.
- WAIT: one cycle for RAM latency. Capture rd_data into byte_q and add it to checksum (8-bit, mod 256). Go to SEND.
- SEND: hand byte_q to the serializer and wait for the serializer to finish. Then:
  - If abort=1: go to FIN (no checksum sent).
  - Else if rd_addr==len_q: go to CKSUM.
  - Else: increment rd_addr and go to FETCH.
- CKSUM: send the checksum byte, then go to FIN.
- FIN: pulse done for 1 cycle, clear busy, return to IDLE. A start arriving in the same cycle as done is ignored.
- Serializer handshake:
  - tx_valid/tx_ready; a byte is accepted only when both are high.
  - tx_ready is high only when the serializer is idle.
  - Frame = start bit 0, data bits LSB first, stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles.
  - Byte time = 10*CLKS_PER_BIT cycles.
- Gap: between the stop bit of one byte and the start bit of the next, the line is idle for at most 4 clk_50M cycles.
- Latency: start to the falling edge of the header start bit is at most 3 cycles.
- Boundaries:
  - dump_len=0 sends exactly 1 payload byte.
  - dump_len=2^ADDR_W-1 sends the full RAM; rd_addr must not wrap before CKSUM.
  - abort while IDLE has no effect.
  - abort during the header still lets the header complete, then goes to FIN.
  - A start during busy is dropped, with no queuing.
- uart_tx is registered (no combinational path) to avoid glitches.

Decomposition:
- Package la_pkg holds:
  - FSM state enum (3-bit encoding)
  - HDR_BYTE default
  - function clks_per_bit(CLK_HZ, BAUD)
- Sub-module la_uart_tx_byte: byte serializer with a baud counter, a 4-bit bit index, and a tx_valid/tx_ready handshake. la_dump_uart instantiates it once.

Test Plan:
- Full small dump (CLKS_PER_BIT overridden to 4): RAM[0..3]=11,22,33,44, dump_len=3, start pulse.
  - Required bytes on uart_tx: A5,11,22,33,44,AA.
  - Exactly one done pulse; busy is low afterwards.
- Single byte: dump_len=0, RAM[0]=FF.
  - Required bytes: A5,FF,FF.
  - rd_addr never exceeds 0.
- Abort: assert abort while the 2nd payload byte is on the line, with RAM[0..7]=01..08 and dump_len=7.
  - Required bytes: A5,01,02, then done.
  - No checksum byte is sent.
- Reset mid-frame: assert rst during a data bit.
  - Next cycle: uart_tx=1, busy=0, done=0.
  - A new start then produces a clean A5 header.
- Timing (default CLKS_PER_BIT=434):
  - Every bit is exactly 434 cycles.
  - Inter-byte idle is at most 4 cycles.
  - Start-to-first-falling-edge is at most 3 cycles.
- Start ignored: pulse start while busy, and again in the same cycle as done.
  - Only one frame is emitted.
  - Checksum matches the mod-256 sum of the payload.

Source files
------------

// File: rtl/la_pkg.sv
// Shared types and constants for the logic-analyser UART readout path.
package la_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    FETCH = 3'd2,
    WAIT  = 3'd3,
    SEND  = 3'd4,
    CKSUM = 3'd5,
    FIN   = 3'd6
  } la_state_e;

  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/la_uart_tx_byte.sv
// 8N1 byte serializer: accepts a byte on tx_valid & tx_ready and shifts it out
// LSB first between a start and a stop bit, each CLKS_PER_BIT cycles long.
module la_uart_tx_byte import la_pkg::*; #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       uart_tx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             active;
  logic [3:0]       bit_idx;
  logic [CNT_W-1:0] baud_cnt;
  logic [9:0]       frame;

  assign tx_ready = ~active;

  // Bit timing and line driver; uart_tx is driven straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      active   <= 1'b0;
      bit_idx  <= 4'd0;
      baud_cnt <= '0;
      frame    <= '1;
      uart_tx  <= 1'b1;
    end else if (!active) begin
      if (tx_valid) begin
        active   <= 1'b1;
        bit_idx  <= 4'd0;
        baud_cnt <= '0;
        frame    <= {1'b1, tx_data, 1'b0};
        uart_tx  <= 1'b0;
      end
    end else if (baud_cnt != CNT_LAST) begin
      baud_cnt <= baud_cnt + CNT_W'(1);
    end else begin
      baud_cnt <= '0;
      if (bit_idx == 4'd9) begin
        active  <= 1'b0;
        uart_tx <= 1'b1;
      end else begin
        bit_idx <= bit_idx + 4'd1;
        uart_tx <= frame[bit_idx + 4'd1];
      end
    end
  end

endmodule

// File: rtl/la_dump_uart.sv
// Capture-RAM readout: streams header, RAM[0..dump_len] and a mod-256 checksum
// over the UART, one RAM read per payload byte.
module la_dump_uart import la_pkg::*; #(
  parameter int         CLK_HZ       = 50000000,
  parameter int         BAUD         = 115200,
  parameter int         ADDR_W       = 17,
  parameter logic [7:0] HDR_BYTE     = HDR_BYTE_DEF,
  parameter int         CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD)
) (
  input  logic              clk_50M,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] dump_len,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              uart_tx,
  output logic              busy,
  output logic              done
);

  la_state_e         state, state_next;
  logic [ADDR_W-1:0] len_q;
  logic [7:0]        checksum;
  logic [7:0]        byte_q;
  logic              sent_q;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic              start_ok;

  assign start_ok = (state == IDLE) && (state_next == HDR);

  // State register.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and serializer request; sent_q splits SEND/CKSUM into
  // "hand over the byte" and "wait for it to leave the line".
  always_comb begin
    state_next = state;
    tx_valid   = 1'b0;
    tx_data    = byte_q;
    case (state)
      IDLE: begin
        // done is high in the cycle right after FIN; a start there is dropped
        if (start && !done) begin
          state_next = HDR;
        end else begin
          state_next = IDLE;
        end
      end
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = HDR_BYTE;
        if (tx_ready) begin
          state_next = FETCH;
        end else begin
          state_next = HDR;
        end
      end
      FETCH: state_next = WAIT;
      WAIT:  state_next = SEND;
      SEND: begin
        if (!sent_q) begin
          if (abort) begin
            if (tx_ready) begin
              state_next = FIN;
            end else begin
              state_next = SEND;
            end
          end else begin
            tx_valid = 1'b1;
          end
        end else if (tx_ready) begin
          if (abort) begin
            state_next = FIN;
          end else if (rd_addr == len_q) begin
            state_next = CKSUM;
          end else begin
            state_next = FETCH;
          end
        end else begin
          state_next = SEND;
        end
      end
      CKSUM: begin
        tx_data = checksum;
        if (!sent_q) begin
          tx_valid = 1'b1;
        end else if (tx_ready) begin
          state_next = FIN;
        end else begin
          state_next = CKSUM;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: address walk, checksum, byte capture and status flags.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      len_q    <= '0;
      rd_addr  <= '0;
      checksum <= 8'd0;
      byte_q   <= 8'd0;
      sent_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= (state == FIN);
      if (state == FIN) begin
        busy <= 1'b0;
      end else if (start_ok) begin
        busy <= 1'b1;
      end
      if (state_next != state) begin
        sent_q <= 1'b0;
      end else if (tx_valid && tx_ready) begin
        sent_q <= 1'b1;
      end
      if (start_ok) begin
        len_q    <= dump_len;
        rd_addr  <= '0;
        checksum <= 8'd0;
      end else if (state == WAIT) begin
        byte_q   <= rd_data;
        checksum <= checksum + rd_data;
      end else if ((state == SEND) && (state_next == FETCH)) begin
        // only reached when rd_addr != len_q, so the address never wraps
        rd_addr <= rd_addr + ADDR_W'(1);
      end
    end
  end

  la_uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk     (clk_50M),
    .rst     (rst),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .uart_tx (uart_tx)
  );

endmodule

// File: tb/tb_la_dump_uart.sv
// Bench for la_dump_uart: a fast instance (4 clocks/bit) for function and a
// default-rate instance for bit timing, sharing one RAM model and one line decoder.
module tb_la_dump_uart;

  localparam int AW    = 17;
  localparam int CPB_F = 4;
  localparam int CPB_T = 434;

  logic clk_50M = 1'b0;
  always #10 clk_50M = ~clk_50M;

  logic          rst, start_drv, sel, abort;
  logic [AW-1:0] dump_len;
  logic          start_f, start_t;
  logic [AW-1:0] rd_addr_f, rd_addr_t, rd_addr_m;
  logic [7:0]    rd_data_f, rd_data_t;
  logic          uart_tx_f, uart_tx_t, busy_f, busy_t, done_f, done_t;
  logic          busy_m, done_m, line;

  logic [7:0] ram [0:(1<<AW)-1];

  assign start_f   = start_drv & ~sel;
  assign start_t   = start_drv & sel;
  assign busy_m    = sel ? busy_t : busy_f;
  assign done_m    = sel ? done_t : done_f;
  assign rd_addr_m = sel ? rd_addr_t : rd_addr_f;
  assign line      = uart_tx_f & uart_tx_t;

  always @(posedge clk_50M) begin
    rd_data_f <= ram[rd_addr_f];
    rd_data_t <= ram[rd_addr_t];
  end

  la_dump_uart #(
    .CLK_HZ(50000000), .BAUD(115200), .ADDR_W(AW), .HDR_BYTE(8'hA5), .CLKS_PER_BIT(CPB_F)
  ) dut_f (
    .clk_50M(clk_50M), .rst(rst), .start(start_f), .abort(abort), .dump_len(dump_len),
    .rd_addr(rd_addr_f), .rd_data(rd_data_f), .uart_tx(uart_tx_f), .busy(busy_f), .done(done_f)
  );

  la_dump_uart #(
    .ADDR_W(AW)
  ) dut_t (
    .clk_50M(clk_50M), .rst(rst), .start(start_t), .abort(abort), .dump_len(dump_len),
    .rd_addr(rd_addr_t), .rd_data(rd_data_t), .uart_tx(uart_tx_t), .busy(busy_t), .done(done_t)
  );

  int checks = 0;
  int errors = 0;
  int cpb    = CPB_F;
  int rx_cnt = 0;
  int done_cnt = 0;
  logic [7:0]    exp_q[$];
  logic [7:0]    model_q[$];
  logic [AW-1:0] max_addr;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected frame from the RAM contents: header, payload (possibly cut short
  // after n_pay bytes by abort), then the mod-256 sum when not aborted.
  task automatic build_model(input int len, input int n_pay);
    logic [7:0] sum;
    sum = 8'd0;
    model_q.delete();
    model_q.push_back(8'hA5);
    for (int i = 0; i <= len; i++) begin
      if (n_pay >= 0 && i >= n_pay) break;
      model_q.push_back(ram[i]);
      sum = sum + ram[i];
    end
    if (n_pay < 0) model_q.push_back(sum);
  endtask

  task automatic pin(input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                     input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
    logic [7:0] arr [6];
    arr = '{b0, b1, b2, b3, b4, b5};
    check("model_len", model_q.size(), n);
    for (int i = 0; i < n && i < model_q.size(); i++) check("model_pin", model_q[i], arr[i]);
  endtask

  always @(negedge clk_50M) begin
    if (done_m === 1'b1) done_cnt++;
    if (start_drv && !busy_m) max_addr <= '0;
    else if (busy_m && rd_addr_m > max_addr) max_addr <= rd_addr_m;
  end

  // Line decoder: aligns to each falling edge, requires every bit to hold for
  // exactly cpb samples, checks framing, byte value and inter-byte idle gap.
  initial begin : rx_mon
    logic [9:0] bits;
    bit glitch, discard, armed;
    int gap;
    armed = 1'b0;
    gap   = 0;
    forever begin
      @(negedge clk_50M);
      if (rst || line) begin
        gap++;
      end else begin
        if (armed) check("idle_gap_le4", (gap <= 4) ? gap : 99, gap);
        glitch  = 1'b0;
        discard = 1'b0;
        for (int b = 0; b < 10; b++) begin
          for (int c = 0; c < cpb; c++) begin
            if (!(b == 0 && c == 0)) @(negedge clk_50M);
            if (rst) discard = 1'b1;
            if (c == 0) bits[b] = line;
            else if (line !== bits[b]) glitch = 1'b1;
          end
        end
        armed = 1'b0;
        gap   = 0;
        if (!discard) begin
          check("start_stop_bits", {bits[9], bits[0]}, 2'b10);
          check("bit_width", glitch, 0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_byte: got %02h, expected no byte", bits[8:1]);
          end else begin
            check("rx_byte", bits[8:1], exp_q.pop_front());
            armed = (exp_q.size() > 0);
          end
          rx_cnt++;
        end
      end
    end
  end

  task automatic run_dump(input int len, input bit poke_busy, input bit poke_done,
                          input int abort_byte, input int exp_last);
    int d0, r0, lat, bound, guard;
    bit seen;
    exp_q = model_q;
    d0    = done_cnt;
    r0    = rx_cnt;
    bound = (len + 4) * 10 * cpb + 200;
    dump_len = AW'(len);
    @(negedge clk_50M); start_drv = 1'b1;
    @(negedge clk_50M); start_drv = 1'b0;
    check("busy_rise", busy_m, 1);
    lat = 1;
    while (line && lat < 8) begin @(negedge clk_50M); lat++; end
    check("start_latency_le3", (lat <= 3) ? 1 : lat, 1);
    if (poke_busy) begin
      repeat (20) @(negedge clk_50M);
      start_drv = 1'b1;
      dump_len  = '0;
      @(negedge clk_50M); start_drv = 1'b0;
    end
    if (abort_byte >= 0) begin
      guard = 0;
      while ((rx_cnt - r0) < abort_byte && guard < bound) begin @(negedge clk_50M); guard++; end
      while (line && guard < bound) begin @(negedge clk_50M); guard++; end
      check("abort_sync", (guard < bound) ? 1 : 0, 1);
      repeat (6) @(negedge clk_50M);
      abort = 1'b1;
    end
    seen  = 1'b0;
    guard = 0;
    while (!seen && guard < bound) begin
      @(negedge clk_50M);
      guard++;
      if (done_m === 1'b1) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    check("max_rd_addr", max_addr, exp_last);
    if (poke_done) start_drv = 1'b1;
    @(negedge clk_50M);
    start_drv = 1'b0;
    abort     = 1'b0;
    repeat (30) @(negedge clk_50M);
    check("done_pulses", done_cnt - d0, 1);
    check("busy_after", busy_m, 0);
    check("bytes_left", exp_q.size(), 0);
  endtask

  initial begin : main
    int r0, guard;
    rst = 1'b1; start_drv = 1'b0; sel = 1'b0; abort = 1'b0; dump_len = '0;
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    repeat (3) @(negedge clk_50M);
    check("rst_tx_f", uart_tx_f, 1);
    check("rst_busy_f", busy_f, 0);
    check("rst_done_f", done_f, 0);
    check("rst_addr_f", rd_addr_f, 0);
    check("rst_tx_t", uart_tx_t, 1);
    check("rst_busy_t", busy_t, 0);
    rst = 1'b0;
    @(negedge clk_50M);

    ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'h44;
    build_model(3, -1);
    pin(6, 8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA);
    run_dump(3, 1'b0, 1'b0, -1, 3);

    // reset during a data bit of the first payload byte
    build_model(3, -1);
    exp_q = model_q;
    r0 = rx_cnt;
    dump_len = AW'(3);
    @(negedge clk_50M); start_drv = 1'b1;
    @(negedge clk_50M); start_drv = 1'b0;
    guard = 0;
    while ((rx_cnt - r0) < 1 && guard < 500) begin @(negedge clk_50M); guard++; end
    while (line && guard < 500) begin @(negedge clk_50M); guard++; end
    check("rst_sync", (guard < 500) ? 1 : 0, 1);
    repeat (10) @(negedge clk_50M);
    rst = 1'b1;
    @(negedge clk_50M);
    check("midrst_tx", uart_tx_f, 1);
    check("midrst_busy", busy_f, 0);
    check("midrst_done", done_f, 0);
    @(negedge clk_50M);
    rst = 1'b0;
    exp_q.delete();
    repeat (60) @(negedge clk_50M);
    check("midrst_rx_count", rx_cnt - r0, 1);

    ram[0] = 8'hFF;
    build_model(0, -1);
    pin(3, 8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00);
    run_dump(0, 1'b0, 1'b0, -1, 0);

    abort = 1'b1;
    repeat (5) @(negedge clk_50M);
    check("idle_abort_busy", busy_f, 0);
    check("idle_abort_line", line, 1);
    abort = 1'b0;

    for (int i = 0; i < 8; i++) ram[i] = 8'(i + 1);
    build_model(7, 2);
    pin(3, 8'hA5, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00);
    run_dump(7, 1'b0, 1'b0, 2, 1);

    ram[0] = 8'h10; ram[1] = 8'h20; ram[2] = 8'h30;
    build_model(2, -1);
    pin(5, 8'hA5, 8'h10, 8'h20, 8'h30, 8'h60, 8'h00);
    run_dump(2, 1'b1, 1'b1, -1, 2);

    sel = 1'b1;
    cpb = CPB_T;
    ram[0] = 8'h55; ram[1] = 8'hC3;
    build_model(1, -1);
    pin(4, 8'hA5, 8'h55, 8'hC3, 8'h18, 8'h00, 8'h00);
    run_dump(1, 1'b0, 1'b0, -1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
